spi2dac_mc: RTL and testbench
=============================

# spi2dac_mc

Parametrised SPI write controller for Microchip MCP49xx-family DACs (single-channel MCP4911 or dual-channel MCP4922-style parts, 8–12-bit). It accepts one sample per load/ready handshake and serialises a 16-bit command frame. It drives SCK, CS and LDAC, with selectable latch behaviour so multi-channel updates can be made simultaneous. It sits between sample-generation logic (NCO, echo/filter datapath) and the DE1 DAC header pins, and replaces the fixed 10-bit single-channel SPI writer.

## Interface
Parameters:
- DATA_W, 10: sample width, legal 8..12.
- NUM_CH, 1: DAC channels, 1 or 2.
- CLK_DIV, 25: SCK half-period in sysclk cycles (default 1 MHz SCK at 50 MHz); minimum 2.
- SYNC_LD, 0: latch mode. 0 = LDAC pulse after every frame. 1 = LDAC pulse only after a frame accepted with last=1.
- BUF, 1'b1: Vref buffer bit.
- GA_N, 1'b1: gain bit (1 = 1x).
- SHDN_N, 1'b1: active bit.

Ports:
- sysclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  sample, unsigned.
- ch_sel  in  1  channel (0 = A, 1 = B); ignored when NUM_CH=1.
- last  in  1  marks the final channel of a synchronous update; used only when SYNC_LD=1.
- load  in  1  request; a transfer is accepted on a cycle with load && ready.
- ready  out  1  high only in IDLE.
- busy  out  1  equal to ~ready.
- dac_sdi  out  1  serial data, MSB first.
- dac_cs  out  1  chip select, active low.
- dac_sck  out  1  SPI clock, idles low.
- dac_ld  out  1  LDAC, active low.

## Operation
- Frame (16 bits, MSB first) is {AB, BUF, GA_N, SHDN_N, D11..D0}.
  - AB = ch_sel when NUM_CH=2, otherwise 0.
  - data_in is left-justified into D11..D(12-DATA_W); lower bits are 0.
- On accept, frame, last and ch_sel are captured. Input changes during the frame have no effect.
- State machine, with a half-period counter reloaded with CLK_DIV-1 on every state entry:
  - IDLE: cs=1, sck=0, ld=1. On accept, go to SETUP.
  - SETUP: cs=0, sdi=frame[15], sck=0. After CLK_DIV cycles, go to SHIFT.
  - SHIFT: 32 half-periods. sck=1 in odd half-periods. The shift register shifts left at the end of each high half-period, so sdi changes on the sck falling edge and the DAC samples on the rising edge. After the 32nd half-period, go to CS_HIGH.
  - CS_HIGH: cs=1, sck=0, sdi=0 for CLK_DIV cycles. Then go to LDAC if a pulse is due, else IDLE.
  - LDAC: ld=0 for 2*CLK_DIV cycles, then IDLE.
- A pulse is due when SYNC_LD=0, or when SYNC_LD=1 and the captured last=1.
- load while busy is ignored, not queued.
- All outputs are registered; no glitches on sck, cs or ld.

## Timing
- Reset values: dac_cs=1, dac_sck=0, dac_ld=1, dac_sdi=0, ready=1, busy=0, state=IDLE.
- Reset asserted mid-frame aborts immediately to these values; no partial LDAC pulse.
- Accept at edge T: cs falls at T+1 and sdi=bit15 is valid from the same cycle.
- First sck rise at T+1+CLK_DIV. Rise k (1..16) at T+1+(2k-1)*CLK_DIV.
- cs rises at T+1+33*CLK_DIV.
- ld low from T+1+34*CLK_DIV through T+36*CLK_DIV.
- ready returns at T+1+36*CLK_DIV with a pulse, or T+1+34*CLK_DIV without.
- At the defaults: 901 or 851 cycles respectively.
- Back-to-back: load held high is accepted in the first ready cycle, so ready is high for exactly one cycle.

## Structure
- spi_dac_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, CS_HIGH, LDAC);
  - FRAME_W=16;
  - bit-position constants AB_BIT=15, BUF_BIT=14, GA_BIT=13, SHDN_BIT=12, DATA_MSB=11;
  - a function that builds the frame from (ch, data).
- Sub-module spi_half_tick: loadable down-counter that pulses at terminal count and restarts on every state entry. It is shared with future ADC SPI readers.

## Test plan
- Defaults, data_in=10'h2AA, one load → 16 sck rises. Sampled bits = 16'h7AA8. cs low for 33*25 cycles. ld low for 50 cycles. ready back after 901 cycles.
- NUM_CH=2, DATA_W=12, CLK_DIV=2: ch_sel=1, data=12'hFFF → frame 16'hFFFF. Then ch_sel=0, data=12'h000 → frame 16'h7000.
- SYNC_LD=1, NUM_CH=2: frame A with last=0, then frame B with last=1 → no ld pulse after A, exactly one 2*CLK_DIV pulse after B.
- load pulsed repeatedly during a frame → ignored; only the first data sampled; ready timing unchanged. Load held high → consecutive frames with one-cycle ready gaps.
- rst_n dropped at the 7th sck rise → outputs return to reset values within the same cycle. A new load after release produces a complete, correct frame.

Source files
------------

// File: rtl/spi2dac_mc_pkg.sv
// Shared types and frame layout for the MCP49xx SPI write controller.
package spi_dac_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CS_HIGH, LDAC} state_t;

  localparam int FRAME_W  = 16;
  localparam int AB_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_MSB = 11;

  function automatic logic [FRAME_W-1:0] build_frame(input logic ab,
                                                     input logic buf_en,
                                                     input logic ga_n,
                                                     input logic shdn_n,
                                                     input logic [DATA_MSB:0] d12);
    logic [FRAME_W-1:0] f;
    f              = '0;
    f[AB_BIT]      = ab;
    f[BUF_BIT]     = buf_en;
    f[GA_BIT]      = ga_n;
    f[SHDN_BIT]    = shdn_n;
    f[DATA_MSB:0]  = d12;
    return f;
  endfunction

endpackage

// File: rtl/spi2dac_mc_if.sv
// Sample handshake plus DAC header pins for spi2dac_mc.
interface spi2dac_mc_if #(parameter int DATA_W = 10);
  logic [DATA_W-1:0] data_in;
  logic              ch_sel;
  logic              last;
  logic              load;
  logic              ready;
  logic              busy;
  logic              dac_sdi;
  logic              dac_cs;
  logic              dac_sck;
  logic              dac_ld;

  modport master (output data_in, ch_sel, last, load,
                  input  ready, busy, dac_sdi, dac_cs, dac_sck, dac_ld);

  modport slave  (input  data_in, ch_sel, last, load,
                  output ready, busy, dac_sdi, dac_cs, dac_sck, dac_ld);
endinterface

// File: rtl/spi2dac_mc_half_tick.sv
// Reloadable half-period down-counter; ticks at terminal count and auto-reloads.
module spi_half_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi2dac_mc.sv
// SPI write controller for MCP4911/MCP4922-style DACs: one 16-bit frame per
// load/ready handshake, with optional LDAC deferral for simultaneous updates.
module spi2dac_mc
  import spi_dac_pkg::*;
#(
  parameter int   DATA_W  = 10,
  parameter int   NUM_CH  = 1,
  parameter int   CLK_DIV = 25,
  parameter int   SYNC_LD = 0,
  parameter logic BUF     = 1'b1,
  parameter logic GA_N    = 1'b1,
  parameter logic SHDN_N  = 1'b1
) (
  input  logic          sysclk,
  input  logic          rst_n,
  spi2dac_mc_if.slave   bus
);

  localparam int D_W = DATA_MSB + 1;

  state_t               r_state;
  state_t               w_next;
  logic                 w_tick;
  logic                 w_restart;
  logic                 w_accept;
  logic                 w_pulse_due;
  logic                 w_ab;
  logic [DATA_MSB:0]    w_d12;
  logic [4:0]           r_half;
  logic [FRAME_W-1:0]   r_shreg;
  logic                 r_last;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_cs;
  logic                 r_sck;
  logic                 r_ld;
  logic                 r_sdi;
  logic                 w_cs;
  logic                 w_sck;
  logic                 w_ld;
  logic                 w_sdi;

  assign w_d12       = D_W'(bus.data_in) << (D_W - DATA_W);
  assign w_ab        = (NUM_CH == 2) ? bus.ch_sel : 1'b0;
  assign w_accept    = bus.load && r_ready && (r_state == IDLE);
  assign w_pulse_due = (SYNC_LD == 0) || r_last;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk       (sysclk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // r_half counts half-periods in SHIFT (even = sck high) and in LDAC.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   if (w_tick) w_next = SHIFT;
      SHIFT:   if (w_tick && (r_half == 5'd31)) w_next = CS_HIGH;
      CS_HIGH: if (w_tick) w_next = w_pulse_due ? LDAC : IDLE;
      LDAC:    if (w_tick && r_half[0]) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    w_restart = (w_next != r_state);
    w_cs      = !((r_state == SETUP) || (r_state == SHIFT));
    w_sck     = (r_state == SHIFT) && !r_half[0];
    w_sdi     = ((r_state == SETUP) || (r_state == SHIFT)) ? r_shreg[FRAME_W-1] : 1'b0;
    w_ld      = (r_state != LDAC);
  end

  // Pin drivers lag the state by one cycle so every output comes from a flop.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_half  <= 5'd0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
      r_ld    <= 1'b1;
      r_sdi   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_half <= 5'd0;
      end else if (w_tick && ((r_state == SHIFT) || (r_state == LDAC))) begin
        r_half <= r_half + 5'd1;
      end
      r_ready <= (r_state == IDLE) && !w_accept;
      r_busy  <= !((r_state == IDLE) && !w_accept);
      r_cs    <= w_cs;
      r_sck   <= w_sck;
      r_ld    <= w_ld;
      r_sdi   <= w_sdi;
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_accept) begin
      r_shreg <= build_frame(w_ab, BUF, GA_N, SHDN_N, w_d12);
      r_last  <= bus.last;
    end else if ((r_state == SHIFT) && w_tick && !r_half[0]) begin
      r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
    end
  end

  assign bus.ready   = r_ready;
  assign bus.busy    = r_busy;
  assign bus.dac_cs  = r_cs;
  assign bus.dac_sck = r_sck;
  assign bus.dac_ld  = r_ld;
  assign bus.dac_sdi = r_sdi;

endmodule

// File: tb/tb_spi2dac_mc.sv
// Directed + randomized bench for spi2dac_mc: a default single-channel instance
// and a dual-channel, 12-bit, CLK_DIV=2, synchronous-LDAC instance.
module tb_spi2dac_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  spi2dac_mc_if #(.DATA_W(10)) ifa ();
  spi2dac_mc_if #(.DATA_W(12)) ifb ();

  spi2dac_mc dut_a (
    .sysclk (clk),
    .rst_n  (rst_a_n),
    .bus    (ifa)
  );

  spi2dac_mc #(.DATA_W(12), .NUM_CH(2), .CLK_DIV(2), .SYNC_LD(1)) dut_b (
    .sysclk (clk),
    .rst_n  (rst_b_n),
    .bus    (ifb)
  );

  int   n_vec = 0;
  int   n_err = 0;
  bit   sel   = 1'b0;

  logic m_sck, m_sdi, m_cs, m_ld, m_ready, m_busy;
  assign m_sck   = sel ? ifb.dac_sck : ifa.dac_sck;
  assign m_sdi   = sel ? ifb.dac_sdi : ifa.dac_sdi;
  assign m_cs    = sel ? ifb.dac_cs  : ifa.dac_cs;
  assign m_ld    = sel ? ifb.dac_ld  : ifa.dac_ld;
  assign m_ready = sel ? ifb.ready   : ifa.ready;
  assign m_busy  = sel ? ifb.busy    : ifa.busy;

  logic [15:0] bits;
  int nrise, first_rise, cs_fall, cs_low, ld_start, ld_low, ready_at, busy_bad;
  bit aborted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] d, input logic ch, input logic lst, input logic req);
    if (sel) begin
      ifb.data_in = d;       ifb.ch_sel = ch; ifb.last = lst; ifb.load = req;
    end else begin
      ifa.data_in = d[9:0];  ifa.ch_sel = ch; ifa.last = lst; ifa.load = req;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cs"},    32'(m_cs),    32'd1);
    chk({tag, ".sck"},   32'(m_sck),   32'd0);
    chk({tag, ".ld"},    32'(m_ld),    32'd1);
    chk({tag, ".sdi"},   32'(m_sdi),   32'd0);
    chk({tag, ".ready"}, 32'(m_ready), 32'd1);
    chk({tag, ".busy"},  32'(m_busy),  32'd0);
  endtask

  // Reference frame: {AB, BUF=1, GA_N=1, SHDN_N=1, data left-justified in 12 bits}.
  function automatic int exp_frame(input int d, input int ch);
    int dw;
    int ab;
    dw = sel ? 12 : 10;
    ab = sel ? ch : 0;
    return ab * 32768 + 16384 + 8192 + 4096 + d * (1 << (12 - dw));
  endfunction

  // One transfer; cycle k counts falling edges after the accepting rising edge.
  task automatic xfer(input logic [11:0] d, input logic ch, input logic lst,
                      input bit noisy, input bit hold, input int abort_rise);
    bit prev;
    bits = '0; nrise = 0; first_rise = -1; cs_fall = -1; cs_low = 0;
    ld_start = -1; ld_low = 0; ready_at = -1; busy_bad = 0; aborted = 1'b0;
    @(negedge clk);
    chk("pre.ready", 32'(m_ready), 32'd1);
    drive(d, ch, lst, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) drive(d, ch, lst, 1'b0);
    prev = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (m_sck && !prev) begin
        nrise++;
        bits = {bits[14:0], m_sdi};
        if (nrise == 1) first_rise = k;
      end
      prev = m_sck;
      if (!m_cs) begin
        cs_low++;
        if (cs_fall < 0) cs_fall = k;
      end
      if (!m_ld) begin
        ld_low++;
        if (ld_start < 0) ld_start = k;
      end
      if (m_busy !== !m_ready) busy_bad++;
      if (abort_rise > 0 && nrise == abort_rise) begin
        if (sel) rst_b_n = 1'b0; else rst_a_n = 1'b0;
        #1;
        check_reset("abort");
        aborted  = 1'b1;
        ready_at = k;
        break;
      end
      if (m_ready && k > 0) begin
        ready_at = k;
        break;
      end
      if (noisy) drive(12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    if (!hold) drive(d, ch, lst, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int d, input int ch, input int lst);
    int c;
    bit pulse;
    c     = sel ? 2 : 25;
    pulse = sel ? (lst != 0) : 1'b1;
    chk({tag, ".bits"},  32'(bits),     32'(exp_frame(d, ch)));
    chk({tag, ".nrise"}, 32'(nrise),    32'd16);
    chk({tag, ".csfall"},32'(cs_fall),  32'd1);
    chk({tag, ".rise1"}, 32'(first_rise), 32'(1 + c));
    chk({tag, ".cslow"}, 32'(cs_low),   32'(33 * c));
    chk({tag, ".ldlow"}, 32'(ld_low),   pulse ? 32'(2 * c) : 32'd0);
    if (pulse) chk({tag, ".ldstart"}, 32'(ld_start), 32'(1 + 34 * c));
    chk({tag, ".ready"}, 32'(ready_at), pulse ? 32'(1 + 36 * c) : 32'(1 + 34 * c));
    chk({tag, ".busy"},  32'(busy_bad), 32'd0);
  endtask

  initial begin
    int d;
    int ch;
    int lst;
    bit seen;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    sel = 1'b0; drive(12'h0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1; drive(12'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; check_reset("rst_a");
    sel = 1'b1; check_reset("rst_b");
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Default instance: the reference 10'h2AA frame, then random samples.
    sel = 1'b0;
    xfer(12'h2AA, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("dflt", 12'h2AA, 0, 0);
    for (int i = 0; i < 2; i++) begin
      d = int'($urandom_range(0, 1023));
      xfer(12'(d), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 0);
      check_frame("rand_a", d, 0, 0);
    end

    // Dual-channel instance: full-scale B, zero A, then an A/B synchronous pair.
    sel = 1'b1;
    xfer(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check_frame("b_fff", 12'hFFF, 1, 1);
    xfer(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("b_000", 0, 0, 0);
    d = int'($urandom_range(0, 4095));
    xfer(12'(d), 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("sync_a", d, 0, 0);
    d = int'($urandom_range(0, 4095));
    xfer(12'(d), 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check_frame("sync_b", d, 1, 1);
    for (int i = 0; i < 6; i++) begin
      d   = int'($urandom_range(0, 4095));
      ch  = int'($urandom_range(0, 1));
      lst = int'($urandom_range(0, 1));
      xfer(12'(d), 1'(ch), 1'(lst), 1'b0, 1'b0, 0);
      check_frame("rand_b", d, ch, lst);
    end

    // Load and data toggled throughout a frame must not disturb it.
    sel = 1'b0;
    d = int'($urandom_range(0, 1023));
    xfer(12'(d), 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_frame("noisy", d, 0, 0);

    // Load held high: re-accepted after exactly one ready cycle.
    sel = 1'b1;
    d = int'($urandom_range(0, 4095));
    xfer(12'(d), 1'b1, 1'b1, 1'b0, 1'b1, 0);
    check_frame("hold", d, 1, 1);
    @(negedge clk);
    chk("hold.reaccept", 32'(m_ready), 32'd0);
    @(negedge clk);
    chk("hold.cs", 32'(m_cs), 32'd0);
    drive(12'(d), 1'b1, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (m_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold.done", 32'(seen), 32'd1);

    // Reset at the 7th SCK rise, then a clean frame afterwards.
    sel = 1'b0;
    d = int'($urandom_range(0, 1023));
    xfer(12'(d), 1'b0, 1'b0, 1'b0, 1'b0, 7);
    chk("abort.seen", 32'(aborted), 32'd1);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    d = int'($urandom_range(0, 1023));
    xfer(12'(d), 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("post_abort", d, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
